// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants, sync polarity and coordinate type for the VGA slice.
package vga_pkg;
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam logic SYNC_ACTIVE = 1'b0;
  typedef logic [9:0] coord_t;
  function automatic logic in_range(input coord_t v, input int lo, input int n);
    return int'(v) >= lo && int'(v) < lo + n;
  endfunction
endpackage

// File: rtl/vga_pix_div.sv
// vga_pix_div: divides the system clock down to the pixel rate, producing the PIX_EN strobe and the DAC clock.
module vga_pix_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en,
  output logic vga_clk
);
  localparam int W = $clog2(CLK_DIV);
  if (CLK_DIV < 2 || (CLK_DIV & (CLK_DIV - 1)) != 0) begin : g_bad_div
    $error("vga_pix_div: CLK_DIV must be a power of two >= 2");
  end
  logic [W-1:0] cnt;
  logic [W-1:0] nxt;
  assign nxt    = cnt + W'(1);
  assign pix_en = &cnt;
  // vga_clk tracks the counter MSB so its rising edge lands mid-pixel, after the data edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      vga_clk <= 1'b0;
    end else begin
      cnt     <= nxt;
      vga_clk <= nxt[W-1];
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, visible decode and registered DAC output stage.
// Optional VGA_BORDER_EN forces a white one-pixel frame around the visible area.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic       clk,
  input  logic       rst_n,
  output coord_t     hc,
  output coord_t     vc,
  output logic       vidon,
  output logic       pix_en,
  output logic       frame_start,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  logic       h_end;
  logic       v_end;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;
  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en),
    .vga_clk(vga_clk)
  );
  assign h_end       = int'(hc) == H_TOTAL - 1;
  assign v_end       = int'(vc) == V_TOTAL - 1;
  assign vidon       = int'(hc) < H_VISIBLE && int'(vc) < V_VISIBLE;
  assign frame_start = pix_en && hc == '0 && vc == '0;
  assign vga_sync_n  = 1'b0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      hc <= h_end ? '0 : hc + 10'd1;
      vc <= h_end ? (v_end ? '0 : vc + 10'd1) : vc;
    end
  end
`ifdef VGA_BORDER_EN
  logic border;
  assign border = hc == '0 || int'(hc) == H_VISIBLE - 1 || vc == '0 || int'(vc) == V_VISIBLE - 1;
  assign pix_r  = border ? 8'hFF : r;
  assign pix_g  = border ? 8'hFF : g;
  assign pix_b  = border ? 8'hFF : b;
`else
  assign pix_r = r;
  assign pix_g = g;
  assign pix_b = b;
`endif
  // every pin is sampled from the same hc/vc, giving one pixel of aligned latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs      <= ~SYNC_ACTIVE;
      vga_vs      <= ~SYNC_ACTIVE;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else if (pix_en) begin
      vga_hs      <= in_range(hc, H_VISIBLE + H_FRONT, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vga_vs      <= in_range(vc, V_VISIBLE + V_FRONT, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vga_blank_n <= vidon;
      vga_r       <= vidon ? pix_r : '0;
      vga_g       <= vidon ? pix_g : '0;
      vga_b       <= vidon ? pix_b : '0;
    end
  end
endmodule
